// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high pulses on sig_in in clock cycles, queued in a 2-entry valid/ready FIFO.
// Define PULSE_METER_MINREJ_EN to discard pulses shorter than MIN_WIDTH.
module pulse_width_meter #(
  parameter int WIDTH     = 16,
  parameter int MIN_WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             clr_ovr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_width,
  output logic             out_sat,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WIDTH:0]   e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       fill_q, fill_d, slot;
  logic             ovr_q, ovr_d;
  logic             push_req, push, pop, drop, keep;
`ifdef PULSE_METER_MINREJ_EN
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_WIDTH);
  assign keep = cnt_q >= MIN_W;
`else
  assign keep = 1'b1;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    push_req = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (!sig_in) state_d = ARMED;
        ARMED: if (sig_in) begin
          state_d = MEASURE;
          cnt_d   = WIDTH'(1);
          sat_d   = 1'b0;
        end
        MEASURE: if (sig_in) begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
          sat_d = sat_q | &cnt_q;
        end else begin
          push_req = keep;
          state_d  = ARMED;
          cnt_d    = '0;
          sat_d    = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Entry 0 is always the head; unused entries are kept at zero so an empty FIFO reads 0.
  assign out_valid = |fill_q;
  assign pop       = out_valid & out_ready;
  assign push      = push_req & (fill_q != 2'd2 | pop);
  assign drop      = push_req & ~push;
  always_comb begin
    e0_d   = pop ? e1_q : e0_q;
    e1_d   = pop ? '0 : e1_q;
    slot   = fill_q - 2'(pop);
    fill_d = fill_q + 2'(push) - 2'(pop);
    ovr_d  = drop | (ovr_q & ~clr_ovr);
    if (push && slot == 2'd0) e0_d = {sat_q, cnt_q};
    if (push && slot != 2'd0) e1_d = {sat_q, cnt_q};
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      e0_q    <= '0;
      e1_q    <= '0;
      fill_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      fill_q  <= fill_d;
      ovr_q   <= ovr_d;
    end
  end
  assign {out_sat, out_width} = e0_q;
  assign overrun              = ovr_q;
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed and random stimulus checked against a run-length/queue reference model.
module tb_pulse_width_meter;
  localparam int W    = 4;
  localparam int MAXW = (1 << W) - 1;
`ifdef PULSE_METER_MINREJ_EN
  localparam int MINW = 2;
`else
  localparam int MINW = 1;
`endif
  logic         clock = 0, reset = 0, enable = 0, sig_in = 0, clr_ovr = 0, out_ready = 0;
  logic         out_valid, out_sat, overrun;
  logic [W-1:0] out_width;
  int           checks = 0, errors = 0;
  int           mq[$];
  bit           m_armed, m_ovr;
  int           m_run;

  pulse_width_meter #(.WIDTH(W), .MIN_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in), .clr_ovr(clr_ovr),
    .out_valid(out_valid), .out_ready(out_ready), .out_width(out_width),
    .out_sat(out_sat), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_armed = 0;
    m_run   = 0;
    m_ovr   = 0;
  endtask

  // Pulses are tracked as raw run lengths; saturation is derived only when comparing.
  task automatic model_edge();
    int  pushv;
    bit  drop;
    pushv = -1;
    drop  = 0;
    if (!reset) begin
      model_clear();
      return;
    end
    if (!enable) begin
      m_armed = 0;
      m_run   = 0;
    end else if (!m_armed) begin
      if (!sig_in) m_armed = 1;
    end else if (sig_in) begin
      m_run++;
    end else begin
      if (m_run >= MINW) pushv = m_run;
      m_run = 0;
    end
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (pushv >= 0) begin
      if (mq.size() < 2) mq.push_back(pushv);
      else drop = 1;
    end
    m_ovr = drop ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr);
  endtask

  task automatic compare_all(input string tag);
    bit ev;
    ev = mq.size() > 0;
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_width"}, 32'(out_width), ev ? ((mq[0] > MAXW) ? MAXW : mq[0]) : 0);
    chk({tag, "_sat"}, 32'(out_sat), 32'(ev && mq[0] > MAXW));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input bit en, input bit s, input bit r, input bit c);
    enable    = en;
    sig_in    = s;
    out_ready = r;
    clr_ovr   = c;
    @(posedge clock);
    model_edge();
    #1;
    compare_all("cyc");
  endtask

  task automatic hi(input int n, input bit r);
    repeat (n) step(1, 1, r, 0);
  endtask

  task automatic lo(input bit r);
    step(1, 0, r, 0);
  endtask

  initial begin
    bit s;
    sig_in = 1;
    #3;
    model_clear();
    compare_all("rst");
    chk("rst_width", 32'(out_width), 0);
    chk("rst_valid", 32'(out_valid), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    reset = 1;
    // pulse already high at enable is ignored
    hi(5, 0); lo(0); hi(4, 0); lo(0);
    chk("tp1_head", 32'(out_width), 4);
    chk("tp1_valid", 32'(out_valid), 1);
    step(1, 0, 1, 0);
    chk("tp1_empty", 32'(out_valid), 0);
    hi(20, 0); lo(0);
    chk("tp2_satw", 32'(out_width), 15);
    chk("tp2_sat", 32'(out_sat), 1);
    step(1, 0, 1, 0);
    hi(3, 0); lo(0);
    chk("tp2_w3", 32'(out_width), 3);
    chk("tp2_nosat", 32'(out_sat), 0);
    step(1, 0, 1, 0);
    hi(2, 0); lo(0); hi(3, 0); lo(0); hi(4, 0); lo(0);
    chk("tp3_ovr", 32'(overrun), 1);
    chk("tp3_head", 32'(out_width), 2);
    step(1, 0, 1, 0);
    chk("tp3_second", 32'(out_width), 3);
    step(1, 0, 1, 0);
    chk("tp3_empty", 32'(out_valid), 0);
    step(1, 0, 0, 1);
    chk("tp3_clr", 32'(overrun), 0);
    hi(2, 0); lo(0); hi(3, 0); lo(0); hi(6, 0); lo(1);
    chk("tp4_noovr", 32'(overrun), 0);
    chk("tp4_head", 32'(out_width), 3);
    step(1, 0, 1, 0);
    chk("tp4_last", 32'(out_width), 6);
    step(1, 0, 1, 0);
    hi(5, 0); step(0, 1, 0, 0); hi(4, 0); lo(0);
    chk("tp5_dropped", 32'(out_valid), 0);
    hi(3, 0); lo(0);
    chk("tp5_w3", 32'(out_width), 3);
    step(1, 0, 1, 0);
    hi(1, 0); lo(0);
    chk("tp6_valid", 32'(out_valid), (MINW > 1) ? 0 : 1);
    chk("tp6_width", 32'(out_width), (MINW > 1) ? 0 : 1);
    step(1, 0, 1, 0);
    s = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 0;
        #2;
        model_clear();
        compare_all("arst");
        step(1, s, 0, 0);
        reset = 1;
      end
      if ($urandom_range(0, 149) == 0) hi(17 + $urandom_range(0, 5), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) s = ~s;
      step($urandom_range(0, 49) != 0, s, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Sits directly downstream of the 3-sample glitch filter and consumes its filtered output as `sig_in`.
- Measures each high pulse on `sig_in` in clock cycles.
- Queues completed measurements in a 2-entry FIFO and presents them on a valid/ready interface to the status/capture logic.
- Flags saturated pulses and FIFO overruns.

Parameters:
- WIDTH, 16, bit width of the pulse-length counter and `out_width`.
- MIN_WIDTH, 2, minimum accepted pulse length in samples. Used only when PULSE_METER_MINREJ_EN is defined.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- enable  input  1  measurement enable; low forces IDLE
- sig_in  input  1  filtered signal from the glitch filter
- clr_ovr  input  1  synchronous clear of `overrun`
- out_valid  output  1  FIFO head holds a measurement
- out_ready  input  1  consumer accepts head this cycle
- out_width  output  WIDTH  pulse length of FIFO head, in samples
- out_sat  output  1  FIFO head pulse exceeded 2^WIDTH-1 samples
- overrun  output  1  sticky: a measurement was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, FIFO empty.
  - out_valid=0, out_width=0, out_sat=0, overrun=0.
- Sampling: `sig_in` is sampled at each rising clock edge. No extra synchroniser; the upstream filter is in the same clock domain.
- FSM:
  - IDLE: if enable=1 and sig_in=0, go to ARMED. Waiting for a low sample prevents measuring a pulse already in progress at reset or enable.
  - ARMED: if sig_in=1, go to MEASURE and load counter=1, sat=0.
  - MEASURE, sig_in=1: counter+1. At 2^WIDTH-1 the counter holds its value and sat is set to 1.
  - MEASURE, sig_in=0: push {sat, counter} into the FIFO, go to ARMED, clear counter.
  - enable=0 in any state: go to IDLE on the next edge, counter=0, sat=0. An in-progress pulse is discarded. FIFO contents and overrun are kept.
- Width definition: the number of consecutive edges at which sig_in was sampled 1. Single-sample high is width 1.
- Latency: the measurement is written at the edge where the first low sample is taken. out_valid/out_width/out_sat are registered and visible immediately after that edge. There is no same-cycle bypass.
- Handshake:
  - A transfer occurs at an edge where out_valid=1 and out_ready=1.
  - out_width/out_sat must stay stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
- FIFO:
  - 2 entries, in-order.
  - Push and pop in the same edge are both honoured, including when full: the pop frees a slot and the push is accepted.
  - Push when full with no pop: the new measurement is dropped, FIFO unchanged, overrun<=1.
  - When empty, out_width/out_sat read 0.
- overrun:
  - Cleared by clr_ovr=1.
  - Drop and clr_ovr on the same edge: set wins, overrun=1.
- Reset mid-pulse: all state cleared. The pulse is lost; the next measurement requires a low sample first (IDLE).

Optional Feature:
- Macro: PULSE_METER_MINREJ_EN.
- Defined: on falling-edge detection, a pulse with counter < MIN_WIDTH is discarded (no push, overrun unaffected) and the FSM returns to ARMED.
- Not defined: every completed pulse of width ≥1 is pushed. MIN_WIDTH is ignored.

Test Plan:
- Reset with sig_in=1, then enable=1, hold high 5 cycles, low, high 4 cycles, low, out_ready=1 → no entry for the first pulse; exactly one entry, width=4, sat=0.
- WIDTH=4, pulse high 20 samples, out_ready=1 → width=15, sat=1. Next pulse of 3 samples → width=3, sat=0.
- out_ready=0, three pulses of widths 2, 3, 4 → FIFO holds 2 then 3, overrun=1. Raise out_ready → reads 2, 3, then out_valid=0. Pulse clr_ovr → overrun=0.
- FIFO full and out_ready=1 on the same edge a pulse of width 6 completes → no overrun; subsequent reads 2, 3, 6.
- enable dropped for 1 cycle during a pulse of width 10 → no entry pushed. The next full pulse of width 3 after a low sample → width=3.
- Single-sample pulse (width 1), PULSE_METER_MINREJ_EN with MIN_WIDTH=2 → not pushed. Without the macro → entry width=1.
